// File: rtl/posit_arbiter_pkg.sv
// Shared types and constants for the two-requester posit unit arbiter.
package posit_arbiter_pkg;

  typedef logic [1:0] opcode_t;

  localparam opcode_t op_addsub = 2'b01;

  typedef enum logic [1:0] {
    st_idle  = 2'b00,
    st_issue = 2'b01,
    st_wait  = 2'b10,
    st_resp  = 2'b11
  } arb_state_t;

endpackage

// File: rtl/posit_arbiter_if.sv
// Request/response channels for two requesters plus the shared posit unit port.
interface posit_arbiter_if
  import posit_arbiter_pkg::*;
#(
  parameter int unsigned posit_width = 8
);

  logic                   req0_valid;
  logic                   req0_ready;
  opcode_t                req0_opcode;
  logic [posit_width-1:0] req0_a;
  logic [posit_width-1:0] req0_b;

  logic                   req1_valid;
  logic                   req1_ready;
  opcode_t                req1_opcode;
  logic [posit_width-1:0] req1_a;
  logic [posit_width-1:0] req1_b;

  logic                   rsp0_valid;
  logic                   rsp0_ready;
  logic [posit_width-1:0] rsp0_result;
  logic                   rsp0_zero;
  logic                   rsp0_err;

  logic                   rsp1_valid;
  logic                   rsp1_ready;
  logic [posit_width-1:0] rsp1_result;
  logic                   rsp1_zero;
  logic                   rsp1_err;

  logic                   unit_start;
  opcode_t                unit_opcode;
  logic [posit_width-1:0] unit_a;
  logic [posit_width-1:0] unit_b;
  logic                   unit_done;
  logic                   unit_zero;
  logic [posit_width-1:0] unit_result;

  // Arbiter side
  modport slave (
    input  req0_valid, req0_opcode, req0_a, req0_b,
    input  req1_valid, req1_opcode, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    input  unit_done, unit_zero, unit_result,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    output rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    output unit_start, unit_opcode, unit_a, unit_b
  );

  // Requesters and posit unit side
  modport master (
    output req0_valid, req0_opcode, req0_a, req0_b,
    output req1_valid, req1_opcode, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    output unit_done, unit_zero, unit_result,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_result, rsp0_zero, rsp0_err,
    input  rsp1_valid, rsp1_result, rsp1_zero, rsp1_err,
    input  unit_start, unit_opcode, unit_a, unit_b
  );

endinterface

// File: rtl/posit_rr_grant.sv
// Two-way round-robin grant: on a tie the requester not served last wins.
module posit_rr_grant (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant    = '0;
    grant[0] = req[0] & (~req[1] | last);
    grant[1] = req[1] & (~req[0] | ~last);
  end

endmodule

// File: rtl/posit_arbiter.sv
// Shares one posit unit between two requesters, one op in flight, with a
// WAIT-state timeout that returns an error response instead of a result.
module posit_arbiter
  import posit_arbiter_pkg::*;
#(
  parameter int unsigned posit_width    = 8,
  parameter int unsigned es             = 1,
  parameter int unsigned timeout_cycles = 64
) (
  input  logic            clk,
  input  logic            reset,
  posit_arbiter_if.slave  bus
);

  localparam int unsigned cnt_w = $clog2(timeout_cycles + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout_cycles - 1);

  // es only describes the operand format seen by the unit
  if (es >= posit_width) begin : g_es_check
    $error("es must be smaller than posit_width");
  end

  arb_state_t             state;
  logic                   last;
  logic                   owner;
  logic [cnt_w-1:0]       cnt;
  logic [1:0]             req_vec;
  logic [1:0]             grant;

  logic                   start_q;
  opcode_t                opcode_q;
  logic [posit_width-1:0] a_q;
  logic [posit_width-1:0] b_q;
  logic                   rsp0_valid_q;
  logic                   rsp1_valid_q;
  logic [posit_width-1:0] result_q;
  logic                   zero_q;
  logic                   err_q;
  logic                   owner_ready;

  assign req_vec = {bus.req1_valid, bus.req0_valid};

  posit_rr_grant u_grant (
    .req   (req_vec),
    .last  (last),
    .grant (grant)
  );

  assign bus.req0_ready = (state == st_idle) & grant[0];
  assign bus.req1_ready = (state == st_idle) & grant[1];

  assign owner_ready = owner ? bus.rsp1_ready : bus.rsp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= st_idle;
      last         <= 1'b1;
      owner        <= 1'b0;
      cnt          <= '0;
      start_q      <= 1'b0;
      opcode_q     <= '0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      result_q     <= '0;
      zero_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        st_idle: begin
          if (|grant) begin
            owner    <= grant[1];
            opcode_q <= grant[1] ? bus.req1_opcode : bus.req0_opcode;
            a_q      <= grant[1] ? bus.req1_a      : bus.req0_a;
            b_q      <= grant[1] ? bus.req1_b      : bus.req0_b;
            start_q  <= 1'b1;
            state    <= st_issue;
          end
        end
        st_issue: begin
          start_q <= 1'b0;
          cnt     <= '0;
          state   <= st_wait;
        end
        st_wait: begin
          if (bus.unit_done) begin
            result_q <= bus.unit_result;
            zero_q   <= bus.unit_zero;
            err_q    <= 1'b0;
            rsp0_valid_q <= ~owner;
            rsp1_valid_q <= owner;
            state    <= st_resp;
          end else if (cnt == cnt_last) begin
            // Done on the final WAIT cycle still wins over the timeout
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b1;
            rsp0_valid_q <= ~owner;
            rsp1_valid_q <= owner;
            state    <= st_resp;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        st_resp: begin
          if (owner_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            last         <= owner;
            state        <= st_idle;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign bus.unit_start  = start_q;
  assign bus.unit_opcode = opcode_q;
  assign bus.unit_a      = a_q;
  assign bus.unit_b      = b_q;

  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_result = result_q;
  assign bus.rsp0_zero   = zero_q;
  assign bus.rsp0_err    = err_q;

  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp1_zero   = zero_q;
  assign bus.rsp1_err    = err_q;

endmodule

// File: tb/tb_posit_arbiter.sv
// Directed bench for posit_arbiter with a small behavioural posit unit model.
module tb_posit_arbiter;
  import posit_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  posit_arbiter_if #(.posit_width(8)) bus ();

  posit_arbiter #(
    .posit_width    (8),
    .es             (1),
    .timeout_cycles (64)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int start_cnt = 0;
  int unit_lat  = 1;
  bit unit_dead = 1'b0;
  int lat_cnt   = 0;
  bit busy      = 1'b0;
  logic [7:0] unit_r;

  // Hand-known posit8/es1 results: 1+1 = 2 (0x50); x + (-x) = 0
  function automatic logic [7:0] unit_calc(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] s;
    s = a + b;
    if (a == 8'h40 && b == 8'h40) return 8'h50;
    if (s == 8'h00) return 8'h00;
    return a ^ b;
  endfunction

  always @(posedge clk) begin
    unit_r = unit_calc(bus.unit_a, bus.unit_b);
    if (bus.unit_start) start_cnt <= start_cnt + 1;
    bus.unit_done   <= 1'b0;
    bus.unit_result <= 8'hEE;
    bus.unit_zero   <= 1'b0;
    if (bus.unit_start && !unit_dead) begin
      if (unit_lat <= 1) begin
        bus.unit_done   <= 1'b1;
        bus.unit_result <= unit_r;
        bus.unit_zero   <= (unit_r == 8'h00);
      end else begin
        busy    <= 1'b1;
        lat_cnt <= unit_lat - 1;
      end
    end else if (busy) begin
      if (lat_cnt == 1) begin
        busy            <= 1'b0;
        bus.unit_done   <= 1'b1;
        bus.unit_result <= unit_r;
        bus.unit_zero   <= (unit_r == 8'h00);
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic issue_op(input int who, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int n;
    if (who == 0) begin
      bus.req0_opcode = op; bus.req0_a = a; bus.req0_b = b; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_opcode = op; bus.req1_a = a; bus.req1_b = b; bus.req1_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(who == 0 ? bus.req0_ready : bus.req1_ready) && n < 20) begin
      tick();
      n++;
    end
    check($sformatf("accept_req%0d", who), (who == 0 ? bus.req0_ready : bus.req1_ready), 1);
    tick();
    if (who == 0) bus.req0_valid = 1'b0;
    else          bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int who, output int cycles);
    int n;
    n = 0;
    while (!(who == 0 ? bus.rsp0_valid : bus.rsp1_valid) && n < 100) begin
      tick();
      n++;
    end
    cycles = n;
    check($sformatf("rsp%0d_seen", who), (who == 0 ? bus.rsp0_valid : bus.rsp1_valid), 1);
  endtask

  task automatic ack(input int who);
    if (who == 0) bus.rsp0_ready = 1'b1;
    else          bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    check($sformatf("rsp%0d_drop", who), (who == 0 ? bus.rsp0_valid : bus.rsp1_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    int s;
    bus.req0_valid = 1'b0; bus.req0_opcode = '0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_opcode = '0; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;

    do_reset();
    check("rst_rsp0_valid", bus.rsp0_valid, 0);
    check("rst_rsp1_valid", bus.rsp1_valid, 0);
    check("rst_rsp_result", bus.rsp0_result, 0);
    check("rst_rsp_err", bus.rsp0_err, 0);
    check("rst_unit_start", bus.unit_start, 0);
    check("rst_unit_opcode", bus.unit_opcode, 0);
    check("rst_unit_a", bus.unit_a, 0);
    check("rst_req0_ready_idle", bus.req0_ready, 0);

    // Single op, unit latency 3
    unit_lat = 3;
    issue_op(0, op_addsub, 8'h40, 8'h40);
    check("t1_start", bus.unit_start, 1);
    check("t1_opcode", bus.unit_opcode, 2'b01);
    check("t1_unit_a", bus.unit_a, 8'h40);
    check("t1_unit_b", bus.unit_b, 8'h40);
    s = start_cnt;
    wait_rsp(0, cyc);
    check("t1_latency", cyc, 4);
    check("t1_result", bus.rsp0_result, 8'h50);
    check("t1_zero", bus.rsp0_zero, 0);
    check("t1_err", bus.rsp0_err, 0);
    check("t1_rsp1_idle", bus.rsp1_valid, 0);
    check("t1_one_start", start_cnt, s + 1);
    ack(0);
    check("t1_unit_a_hold", bus.unit_a, 8'h40);

    // Contention after reset: req0 first, then req1, then alternation
    do_reset();
    unit_lat = 1;
    bus.req0_opcode = op_addsub; bus.req0_a = 8'h40; bus.req0_b = 8'h40; bus.req0_valid = 1'b1;
    bus.req1_opcode = op_addsub; bus.req1_a = 8'h40; bus.req1_b = 8'hC0; bus.req1_valid = 1'b1;
    #1;
    check("t2_tie_req0_ready", bus.req0_ready, 1);
    check("t2_tie_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    #1;
    check("t2_busy_req1_ready", bus.req1_ready, 0);
    wait_rsp(0, cyc);
    check("t2_r0_result", bus.rsp0_result, 8'h50);
    check("t2_r0_rsp1_idle", bus.rsp1_valid, 0);
    ack(0);
    check("t2_req1_ready", bus.req1_ready, 1);
    check("t2_req1_unit_a_before", bus.unit_a, 8'h40);
    tick();
    bus.req1_valid = 1'b0;
    check("t2_req1_unit_b", bus.unit_b, 8'hC0);
    wait_rsp(1, cyc);
    check("t2_zero_result", bus.rsp1_result, 8'h00);
    check("t2_zero_flag", bus.rsp1_zero, 1);
    check("t2_zero_err", bus.rsp1_err, 0);
    check("t2_r1_rsp0_idle", bus.rsp0_valid, 0);
    ack(1);
    bus.req0_valid = 1'b1;
    bus.req1_a = 8'h40; bus.req1_b = 8'h40; bus.req1_valid = 1'b1;
    #1;
    check("t2_tie2_req0_ready", bus.req0_ready, 1);
    check("t2_tie2_req1_ready", bus.req1_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    wait_rsp(0, cyc);
    ack(0);
    bus.req0_valid = 1'b1;
    #1;
    check("t2_tie3_req1_ready", bus.req1_ready, 1);
    check("t2_tie3_req0_ready", bus.req0_ready, 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    wait_rsp(1, cyc);
    check("t2_tie3_result", bus.rsp1_result, 8'h50);
    ack(1);

    // Timeout: unit never completes
    unit_dead = 1'b1;
    issue_op(0, op_addsub, 8'h40, 8'h40);
    wait_rsp(0, cyc);
    check("t3_timeout_cycles", cyc, 65);
    check("t3_err", bus.rsp0_err, 1);
    check("t3_result", bus.rsp0_result, 8'h00);
    check("t3_zero", bus.rsp0_zero, 0);
    ack(0);
    unit_dead = 1'b0;
    issue_op(0, op_addsub, 8'h40, 8'h40);
    wait_rsp(0, cyc);
    check("t3_after_err", bus.rsp0_err, 0);
    check("t3_after_result", bus.rsp0_result, 8'h50);
    ack(0);

    // Backpressure; req1 withdraws its request before it can be accepted
    issue_op(0, op_addsub, 8'h40, 8'h40);
    wait_rsp(0, cyc);
    s = start_cnt;
    bus.req1_opcode = op_addsub; bus.req1_a = 8'h40; bus.req1_b = 8'hC0; bus.req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t4_hold_valid_%0d", i), bus.rsp0_valid, 1);
      check($sformatf("t4_hold_result_%0d", i), bus.rsp0_result, 8'h50);
      check($sformatf("t4_req1_blocked_%0d", i), bus.req1_ready, 0);
      tick();
      if (i == 4) bus.req1_valid = 1'b0;
    end
    check("t4_no_start_stall", start_cnt, s);
    ack(0);
    for (int i = 0; i < 4; i++) tick();
    check("t4_no_start_after", start_cnt, s);
    check("t4_rsp1_none", bus.rsp1_valid, 0);

    // Reset while waiting on a slow unit; its late done must be ignored
    unit_lat = 5;
    issue_op(0, op_addsub, 8'h40, 8'hC0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_rsp0_valid", bus.rsp0_valid, 0);
    check("t5_rsp_result", bus.rsp0_result, 0);
    check("t5_rsp_zero", bus.rsp0_zero, 0);
    check("t5_rsp_err", bus.rsp0_err, 0);
    check("t5_unit_start", bus.unit_start, 0);
    check("t5_unit_opcode", bus.unit_opcode, 0);
    check("t5_unit_a", bus.unit_a, 0);
    check("t5_unit_b", bus.unit_b, 0);
    s = start_cnt;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_no_rsp0_%0d", i), bus.rsp0_valid, 0);
      check($sformatf("t5_no_rsp1_%0d", i), bus.rsp1_valid, 0);
      tick();
    end
    check("t5_no_restart", start_cnt, s);
    unit_lat = 1;
    issue_op(1, op_addsub, 8'h40, 8'h40);
    check("t5_fresh_start", bus.unit_start, 1);
    check("t5_fresh_unit_a", bus.unit_a, 8'h40);
    wait_rsp(1, cyc);
    check("t5_fresh_result", bus.rsp1_result, 8'h50);
    check("t5_fresh_zero", bus.rsp1_zero, 0);
    check("t5_fresh_err", bus.rsp1_err, 0);
    ack(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/posit_arbiter.md
POSIT_ARBITER -- requirements
Module: posit_arbiter

Interface
REQ-001 Parameter posit_width, default 8, operand/result width in bits.
REQ-002 Parameter es, default 1, exponent field width; passed through only, no internal use.
REQ-003 Parameter timeout_cycles, default 64, maximum WAIT-state cycles before an op is aborted.
REQ-004 clk  input  1  single clock, all state on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an op.
REQ-007 reqN_ready  output  1  arbiter accepts requester N's op this cycle.
REQ-008 reqN_opcode  input  2  op code, forwarded unchanged to unit_opcode.
REQ-009 reqN_a, reqN_b  input  posit_width  operands.
REQ-010 rspN_valid  output  1  response for requester N available.
REQ-011 rspN_ready  input  1  requester N consumes the response.
REQ-012 rspN_result  output  posit_width  result from the unit.
REQ-013 rspN_zero  output  1  zero flag from the unit.
REQ-014 rspN_err  output  1  op aborted by timeout; result forced to 0.
REQ-015 unit_start  output  1  one-cycle start pulse to the shared posit_top.
REQ-016 unit_opcode  output  2  latched opcode.
REQ-017 unit_a, unit_b  output  posit_width  latched operands.
REQ-018 unit_done, unit_zero  input  1  completion and zero flag from posit_top.
REQ-019 unit_result  input  posit_width  result from posit_top.

Function
REQ-020 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one op in flight.
REQ-021 IDLE: grant = requester with valid; if both valid, the one not served last (round-robin pointer `last`).
REQ-022 IDLE: reqN_ready = 1 only for the granted requester, combinational from valid and `last`; all other states: both ready = 0.
REQ-023 On accept (valid & ready): latch opcode/a/b into unit_* registers, record owner, go to ISSUE.
REQ-024 ISSUE: unit_start = 1 for exactly one cycle, go to WAIT, clear the timeout counter.
REQ-025 WAIT: unit_done ignored during the ISSUE cycle; the first unit_done = 1 seen in WAIT latches unit_result and unit_zero, err = 0, go to RESP.
REQ-026 WAIT: counter increments each cycle; if it reaches timeout_cycles without done, go to RESP with result = 0, zero = 0, err = 1.
REQ-027 RESP: rsp_valid of the owner held at 1, with result/zero/err stable, until the owner's rsp_ready = 1; the other requester's rsp_valid stays 0.
REQ-028 RESP & rspN_ready: rsp_valid drops the next cycle, `last` = owner, go to IDLE; new accept possible in that IDLE cycle (minimum 4 cycles accept-to-accept with 1-cycle unit latency).
REQ-029 unit_opcode/a/b hold their values from accept until the next accept.
REQ-030 reqN_valid dropped by the requester before acceptance: no effect; no op is issued.
REQ-031 unit_done arriving in IDLE, ISSUE or RESP is ignored.
REQ-032 A requester holding valid is granted within 2 ops (starvation bound).

Reset
REQ-033 reset forces, from any state (mid-op included): state IDLE, `last` = 1 (requester 0 wins the first tie).
REQ-034 Reset values: all rsp_* = 0, unit_start = 0, unit_opcode/a/b = 0, counter = 0.
REQ-035 An op in flight at reset is dropped with no response; the next start is issued only after a fresh accept.

Structure
REQ-036 The FSM state encoding and the default opcode constants (2'b01 add/sub) live in the shared posit package.
REQ-037 Round-robin grant logic is a natural sub-module, posit_rr_grant (2 requests, last pointer -> one-hot grant).
REQ-038 posit_top is instantiated in the parent and not inside posit_arbiter.

Verification
REQ-039 Single op: req0 opcode 01, a=0x40, b=0x40, unit model latency 3 -> one start pulse; rsp0_valid with result 0x50, zero 0, err 0.
REQ-040 Contention: req0 and req1 valid in the same cycle after reset -> req0 served first, then req1; the next tie goes to req0 again only after req1.
REQ-041 Zero result: req1 a=0x40, b=0xC0, opcode 01 -> rsp1_result 0x00, rsp1_zero 1.
REQ-042 Timeout: unit model never asserts done -> after 64 WAIT cycles rsp0_err 1, result 0x00; the next op completes normally.
REQ-043 Backpressure: rsp0_ready held 0 for 10 cycles -> rsp0 fields stable, req1 not accepted, no second start.
REQ-044 Reset in WAIT: assert reset 1 cycle -> all outputs 0, no response; the stale unit_done is ignored; a fresh op succeeds.
